// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Drives the register file's single write port. It merges two sources:
//   - single-cycle ALU results, which always win and are never stalled
//   - long-latency memory results, held in a small FIFO with valid/ready
// It also tracks which registers still wait on a memory result, so that
// decode can stall on them.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        busy1,
  output logic        busy2,
  output logic        wen,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  // Pointer width; kept at least 1 so the pointer vectors are never empty.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  // Memory-result FIFO storage and bookkeeping
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  // Set when the value in the output register came from the FIFO
  logic          src_mem;

  // One bit per architectural register: a memory write is still in flight
  logic [31:0]   pending;
  logic [31:0]   pending_next;

  // ready depends only on the stored count, never on mem_valid, so there is
  // no combinational path from the producer back to itself.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign mem_ready = !full;

  // The ALU owns the port whenever it has a result; the FIFO only drains in
  // ALU-free cycles. The head is read straight from storage, so an entry
  // written on an edge can only be popped on a later edge (no bypass).
  assign push      = mem_valid && !full;
  assign pop       = !alu_valid && !empty;
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // FIFO payload storage; contents need no reset because count guards them
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW + 1)'(1);
      end
    end
  end

  // Write-port register: ALU first, then FIFO head; x0 targets are consumed
  // but never raise wen. With nothing to write, address and data hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      src_mem <= 1'b0;
    end else if (alu_valid) begin
      wen     <= (alu_rd != 5'd0);
      waddr   <= alu_rd;
      wdata   <= alu_data;
      src_mem <= 1'b0;
    end else if (pop) begin
      wen     <= (head_rd != 5'd0);
      waddr   <= head_rd;
      wdata   <= head_data;
      src_mem <= 1'b1;
    end else begin
      wen     <= 1'b0;
    end
  end

  // Next pending vector: a committing memory write clears its bit, a new
  // issue sets it, and the issue is applied last so it wins a collision.
  always_comb begin
    pending_next = pending;
    if (wen && src_mem) begin
      pending_next[waddr] = 1'b0;
    end
    if (iss_valid && (iss_rd != 5'd0)) begin
      pending_next[iss_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // x0 can never be waited on, regardless of the stored vector
  assign busy1 = (chk_rs1 != 5'd0) && pending[chk_rs1];
  assign busy2 = (chk_rs2 != 5'd0) && pending[chk_rs2];

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that drives the register file's single write port (wen/waddr/wdata), serving as the writer end of the regfile interface. It merges single-cycle ALU results, which take priority and are never back-pressured, with long-latency memory results, which are buffered in a small FIFO with a valid/ready handshake. It also keeps a pending-write scoreboard so decode can stall on registers whose memory result has not yet committed.

## Interface
Parameters:
- DEPTH, 2, memory-result FIFO entries; power of two, ≥2

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; always accepted
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  FIFO can accept; equals !full (combinational from state only)
- mem_rd  in  5  memory destination register
- mem_data  in  32  memory result
- iss_valid  in  1  decode issued a long-latency op writing iss_rd
- iss_rd  in  5  register to mark pending
- chk_rs1, chk_rs2  in  5 each  decode source registers to check
- busy1, busy2  out  1 each  combinational: pending bit of chk_rs1 / chk_rs2
- wen  out  1  regfile write enable (registered)
- waddr  out  5  regfile write address (registered)
- wdata  out  32  regfile write data (registered)

## Operation
- Reset (rst=0, async): wen=0, waddr=0, wdata=0; FIFO empty, so mem_ready=1; all scoreboard bits 0; internal src_mem flag 0.
- Memory handshake: a result transfers on an edge where mem_valid && mem_ready. Producer holds mem_rd and mem_data stable while mem_valid && !mem_ready.
- Arbitration, evaluated each cycle:
  - alu_valid=1: output register loads {alu_rd, alu_data}; src_mem=0; FIFO not popped.
  - else FIFO non-empty: pop head and load it into the output register; src_mem=1.
  - else: wen=0, waddr and wdata hold their previous values.
- x0 rule: a selected entry with rd==0 still pops/consumes, but it loads wen=0.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Push and pop on the same edge are allowed when non-empty; count is unchanged.
  - Push when full is impossible because ready is low.
  - Pop when empty never occurs.
  - An entry pushed at edge E is eligible for pop no earlier than the cycle after E; there is no FIFO bypass.
- Scoreboard: 32-bit pending vector; bit 0 is hardwired to 0.
  - Set: iss_valid && iss_rd!=0 sets bit iss_rd on the edge.
  - Clear: on an edge where wen=1 && src_mem=1 (the regfile commits the memory write on that edge), clear bit waddr.
  - Same bit set and cleared on the same edge: set wins, because the new issue supersedes the old write.
- busy1/busy2 read the pending vector combinationally; index 0 always returns 0.
- ALU writes never touch the scoreboard. Decode must not issue an ALU op to a pending rd; this is not checked.

## Timing
- ALU latency: alu_valid at cycle N gives wen/waddr/wdata valid during cycle N+1; the regfile writes at the end of N+1.
- Memory latency, no contention: accepted at edge E, output valid during the cycle after E+1, scoreboard clear at the following edge.
- Memory starvation: continuous alu_valid starves the FIFO indefinitely. Once the FIFO fills, mem_ready=0 until the first ALU-free cycle.
- mem_ready rises in the cycle after the pop edge that makes the FIFO not full.
- Reset mid-operation: all FIFO contents and pending bits are discarded immediately; outputs go to their reset values asynchronously.

## Test plan
- Reset and ALU path: rst low for 2 cycles, check wen=0, waddr=0, wdata=0, mem_ready=1. Then drive alu_valid=1, rd=5, data=32'hdeadbeef for one cycle → next cycle wen=1, waddr=5, wdata=32'hdeadbeef; the cycle after, wen=0.
- Scoreboard round trip: iss_valid with rd=3, then chk_rs1=3 → busy1=1. Push mem rd=3, data=32'hcafed00d with no ALU traffic → write appears 2 cycles after acceptance; busy1 stays 1 through that cycle and reads 0 the cycle after.
- Priority and back-pressure (DEPTH=2): alu_valid held for 4 cycles while mem_valid pushes rd=1 and rd=2 → mem_ready=0 after the second push, no mem write during ALU cycles. Drop alu_valid → rd=1 then rd=2 written on consecutive cycles, mem_ready returns to 1.
- x0 suppression: ALU rd=0, data=32'hb105f00d → wen stays 0. Mem rd=0 → FIFO drains with wen=0. iss_rd=0 → busy for rs=0 stays 0.
- Set/clear collision: rd=7 pending, mem write to 7 commits on the same edge as iss_valid rd=7 → busy for 7 remains 1 afterwards.
- Async reset mid-drain: FIFO holding 2 entries and bits 3 and 4 pending, pulse rst low between edges → wen=0 immediately, busy=0 for 3 and 4, mem_ready=1, and no further writes after release.
